// File: rtl/mem_write_monitor_if.sv
// Data-memory store port as seen by the write monitor: one store per cycle
// while memwrite is high.
interface mem_write_monitor_if;
  logic        memwrite;
  logic [31:0] dataadr;
  logic [31:0] writedata;

  modport master (output memwrite, dataadr, writedata);
  modport slave  (input  memwrite, dataadr, writedata);
endinterface

// File: rtl/mem_write_monitor.sv
// Pass/fail responder for self-checking MIPS programs: arms a window with an
// expected (address, data) store and reports PASS on first match or FAIL on timeout.
module mem_write_monitor #(
  parameter int unsigned TIMEOUT_CYCLES = 200
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [31:0]               exp_adr,
  input  logic [31:0]               exp_data,
  mem_write_monitor_if.slave        bus,
  output logic                      busy,
  output logic                      done,
  output logic                      pass,
  output logic [31:0]               cycle_count,
  output logic [15:0]               write_count,
  output logic [15:0]               mismatch_count,
  output logic [31:0]               last_adr,
  output logic [31:0]               last_data
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] PASS = 2'd2;
  localparam logic [1:0] FAIL = 2'd3;

  localparam logic [31:0] LAST_CYCLE = 32'(TIMEOUT_CYCLES - 1);

  logic [1:0]  state, state_nxt;
  logic [31:0] exp_adr_q, exp_data_q;
  logic        store, match, timeout;

  assign store   = (state == RUN) && !start && bus.memwrite;
  assign match   = store && (bus.dataadr == exp_adr_q) && (bus.writedata == exp_data_q);
  assign timeout = (state == RUN) && !start && (cycle_count == LAST_CYCLE);

  // A match on the final window cycle takes precedence over the timeout.
  always_comb begin
    state_nxt = state;
    if (start)        state_nxt = RUN;
    else if (match)   state_nxt = PASS;
    else if (timeout) state_nxt = FAIL;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      exp_adr_q      <= '0;
      exp_data_q     <= '0;
      cycle_count    <= '0;
      write_count    <= '0;
      mismatch_count <= '0;
      last_adr       <= '0;
      last_data      <= '0;
    end else begin
      state <= state_nxt;
      if (start) begin
        exp_adr_q      <= exp_adr;
        exp_data_q     <= exp_data;
        cycle_count    <= '0;
        write_count    <= '0;
        mismatch_count <= '0;
        last_adr       <= '0;
        last_data      <= '0;
      end else if (state == RUN) begin
        cycle_count <= cycle_count + 32'd1;
        if (store && (write_count != '1))
          write_count <= write_count + 16'd1;
        if (store && !match) begin
          if (mismatch_count != '1)
            mismatch_count <= mismatch_count + 16'd1;
          last_adr  <= bus.dataadr;
          last_data <= bus.writedata;
        end
      end
    end
  end

  assign busy = (state == RUN);
  assign done = (state == PASS) || (state == FAIL);
  assign pass = (state == PASS);

endmodule

// File: tb/tb_mem_write_monitor.sv
// Scoreboard bench for mem_write_monitor: each applied cycle queues its
// expected outputs, which are popped and compared once the edge has passed.
module tb_mem_write_monitor;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, start;
  logic [31:0] exp_adr, exp_data;
  logic        busy, done, pass;
  logic [31:0] cycle_count;
  logic [15:0] write_count, mismatch_count;
  logic [31:0] last_adr, last_data;

  mem_write_monitor_if bus();

  mem_write_monitor #(.TIMEOUT_CYCLES(200)) dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .exp_adr        (exp_adr),
    .exp_data       (exp_data),
    .bus            (bus.slave),
    .busy           (busy),
    .done           (done),
    .pass           (pass),
    .cycle_count    (cycle_count),
    .write_count    (write_count),
    .mismatch_count (mismatch_count),
    .last_adr       (last_adr),
    .last_data      (last_data)
  );

  typedef struct {
    string       tag;
    logic        busy, done, pass;
    logic [31:0] cyc;
    logic [15:0] wc, mc;
    logic [31:0] la, ld;
  } exp_t;

  exp_t        sb[$];
  int unsigned vectors     = 0;
  int unsigned miscompares = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic exp_t mk(input string tag, input logic b, input logic dn, input logic p,
                              input logic [31:0] cyc, input logic [15:0] wc, input logic [15:0] mc,
                              input logic [31:0] la, input logic [31:0] ld);
    exp_t e;
    e.tag = tag; e.busy = b; e.done = dn; e.pass = p;
    e.cyc = cyc; e.wc = wc; e.mc = mc; e.la = la; e.ld = ld;
    return e;
  endfunction

  task automatic compare_head();
    exp_t e;
    if (sb.size() == 0) begin
      check_val("sb_empty", 32'd1, 32'd0);
      return;
    end
    e = sb.pop_front();
    check_val({e.tag, ".busy"}, {31'd0, busy}, {31'd0, e.busy});
    check_val({e.tag, ".done"}, {31'd0, done}, {31'd0, e.done});
    check_val({e.tag, ".pass"}, {31'd0, pass}, {31'd0, e.pass});
    check_val({e.tag, ".cycle_count"}, cycle_count, e.cyc);
    check_val({e.tag, ".write_count"}, {16'd0, write_count}, {16'd0, e.wc});
    check_val({e.tag, ".mismatch_count"}, {16'd0, mismatch_count}, {16'd0, e.mc});
    check_val({e.tag, ".last_adr"}, last_adr, e.la);
    check_val({e.tag, ".last_data"}, last_data, e.ld);
  endtask

  // Drive one cycle of stimulus, queue its expected result, then compare after the edge.
  task automatic apply(input logic st, input logic mw, input logic [31:0] a,
                       input logic [31:0] d, input exp_t e);
    start         = st;
    bus.memwrite  = mw;
    bus.dataadr   = a;
    bus.writedata = d;
    sb.push_back(e);
    @(posedge clk);
    #1;
    compare_head();
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; exp_adr = '0; exp_data = '0;
    bus.memwrite = 1'b0; bus.dataadr = '0; bus.writedata = '0;

    apply(0, 0, 0, 0, mk("reset", 0, 0, 0, 0, 0, 0, 0, 0));
    reset = 1'b0;

    // Mismatch then match.
    exp_adr = 32'd18; exp_data = 32'd21;
    apply(1, 0, 0, 0, mk("t1.arm", 1, 0, 0, 0, 0, 0, 0, 0));
    apply(0, 1, 32'h54, 32'd7, mk("t1.miss", 1, 0, 0, 1, 1, 1, 32'h54, 32'd7));
    apply(0, 1, 32'd18, 32'd21, mk("t1.hit", 0, 1, 1, 2, 2, 1, 32'h54, 32'd7));
    apply(0, 1, 32'h54, 32'd9, mk("t1.frozen", 0, 1, 1, 2, 2, 1, 32'h54, 32'd7));

    // No stores: busy for exactly 200 cycles, then FAIL.
    apply(1, 0, 0, 0, mk("t2.arm", 1, 0, 0, 0, 0, 0, 0, 0));
    for (int i = 1; i < 200; i++)
      apply(0, 0, 0, 0, mk("t2.run", 1, 0, 0, 32'(i), 0, 0, 0, 0));
    apply(0, 0, 0, 0, mk("t2.fail", 0, 1, 0, 200, 0, 0, 0, 0));

    // Match on the final window cycle wins over timeout.
    exp_adr = 32'd84; exp_data = 32'd7;
    apply(1, 0, 0, 0, mk("t3.arm", 1, 0, 0, 0, 0, 0, 0, 0));
    for (int i = 1; i < 200; i++)
      apply(0, 0, 0, 0, mk("t3.run", 1, 0, 0, 32'(i), 0, 0, 0, 0));
    apply(0, 1, 32'd84, 32'd7, mk("t3.lastpass", 0, 1, 1, 200, 1, 0, 0, 0));

    // Same store one cycle late lands after FAIL and changes nothing.
    apply(1, 0, 0, 0, mk("t3b.arm", 1, 0, 0, 0, 0, 0, 0, 0));
    for (int i = 1; i < 200; i++)
      apply(0, 0, 0, 0, mk("t3b.run", 1, 0, 0, 32'(i), 0, 0, 0, 0));
    apply(0, 0, 0, 0, mk("t3b.fail", 0, 1, 0, 200, 0, 0, 0, 0));
    apply(0, 1, 32'd84, 32'd7, mk("t3b.late", 0, 1, 0, 200, 0, 0, 0, 0));

    // Full-width compare: data differs only in low bits.
    exp_adr = 32'h70f00ff0; exp_data = 32'd2;
    apply(1, 0, 0, 0, mk("t4.arm", 1, 0, 0, 0, 0, 0, 0, 0));
    apply(0, 1, 32'h70f00ff0, 32'd3, mk("t4.miss", 1, 0, 0, 1, 1, 1, 32'h70f00ff0, 32'd3));
    apply(0, 1, 32'h70f00ff0, 32'd2, mk("t4.hit", 0, 1, 1, 2, 2, 1, 32'h70f00ff0, 32'd3));

    // Store on a start cycle is ignored; restart mid-RUN uses new pair.
    exp_adr = 32'd5; exp_data = 32'd6;
    apply(1, 1, 32'd5, 32'd6, mk("t5.startstore", 1, 0, 0, 0, 0, 0, 0, 0));
    apply(0, 1, 32'd7, 32'd8, mk("t5.miss", 1, 0, 0, 1, 1, 1, 32'd7, 32'd8));
    exp_adr = 32'd9; exp_data = 32'd10;
    apply(1, 1, 32'd5, 32'd6, mk("t5.restart", 1, 0, 0, 0, 0, 0, 0, 0));
    apply(0, 1, 32'd5, 32'd6, mk("t5.oldpair", 1, 0, 0, 1, 1, 1, 32'd5, 32'd6));
    apply(0, 1, 32'd9, 32'd10, mk("t5.newpair", 0, 1, 1, 2, 2, 1, 32'd5, 32'd6));

    // Reset mid-RUN clears everything and beats start/memwrite; IDLE ignores stores.
    exp_adr = 32'd1; exp_data = 32'd2;
    apply(1, 0, 0, 0, mk("t6.arm", 1, 0, 0, 0, 0, 0, 0, 0));
    apply(0, 1, 32'd3, 32'd4, mk("t6.miss1", 1, 0, 0, 1, 1, 1, 32'd3, 32'd4));
    apply(0, 1, 32'd3, 32'd4, mk("t6.miss2", 1, 0, 0, 2, 2, 2, 32'd3, 32'd4));
    reset = 1'b1;
    apply(1, 1, 32'd1, 32'd2, mk("t6.reset", 0, 0, 0, 0, 0, 0, 0, 0));
    reset = 1'b0;
    apply(0, 1, 32'd1, 32'd2, mk("t6.idle1", 0, 0, 0, 0, 0, 0, 0, 0));
    apply(0, 1, 32'd3, 32'd4, mk("t6.idle2", 0, 0, 0, 0, 0, 0, 0, 0));

    if (sb.size() != 0)
      check_val("sb_leftover", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mem_write_monitor.md
# mem_write_monitor

Synthesizable memory-write monitor that sits on the processor's data-memory write port (`memwrite`, `dataadr`, `writedata`), beside data memory, and acts as the pass/fail responder for self-checking MIPS test programs. A test window is armed with an expected (address, data) pair. The block watches every store and reports PASS on the first matching store, or FAIL when no matching store occurs within a bounded cycle budget. While running it counts cycles, stores and mismatching stores, and captures the most recent mismatching store for debug, so FPGA and simulation runs share one checker.

## Interface
- `TIMEOUT_CYCLES`, default 200: length of the test window in RUN cycles. Must be ≥ 1.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle pulse. Arms a new window, samples `exp_adr`/`exp_data` and clears all counters and captures.
- `exp_adr`  in  32  expected store address; sampled only when `start`=1.
- `exp_data`  in  32  expected store data; sampled only when `start`=1.
- `memwrite`  in  1  processor store strobe, one store per high cycle.
- `dataadr`  in  32  store address, valid when `memwrite`=1.
- `writedata`  in  32  store data, valid when `memwrite`=1.
- `busy`  out  1  high while in RUN.
- `done`  out  1  high in PASS or FAIL.
- `pass`  out  1  high only in PASS.
- `cycle_count`  out  32  RUN cycles consumed in the current or last window.
- `write_count`  out  16  stores seen in the window; saturates at 16'hFFFF.
- `mismatch_count`  out  16  non-matching stores; saturates at 16'hFFFF.
- `last_adr`  out  32  address of the most recent mismatching store.
- `last_data`  out  32  data of the most recent mismatching store.

## Operation
- States: IDLE, RUN, PASS, FAIL. `busy`, `done` and `pass` are decoded directly from the state register.
- Reset: state goes to IDLE. Every output and every internal register (expected pair, counters, captures) is cleared to 0.
- IDLE / PASS / FAIL with `start`=1:
  - Latch `exp_adr`/`exp_data`.
  - Clear `cycle_count`, `write_count`, `mismatch_count`, `last_adr`, `last_data`.
  - Go to RUN.
- `memwrite` on a `start` cycle is ignored in every state.
- RUN, each cycle with `start`=0:
  - `cycle_count` += 1.
  - If `memwrite`=1: `write_count` += 1 (saturating).
  - Match is `dataadr`==expected address AND `writedata`==expected data, full 32-bit compare, no masking.
  - Match: go to PASS.
  - Non-matching store: `mismatch_count` += 1 (saturating); capture `dataadr`/`writedata` into `last_adr`/`last_data`; stay in RUN.
  - Timeout: if there is no match and `cycle_count`==TIMEOUT_CYCLES-1 before the increment, go to FAIL.
  - A match on the final window cycle wins over timeout and goes to PASS.
- RUN with `start`=1: restart. Re-latch the expected pair, clear counters, stay in RUN. The store on that cycle is ignored.
- PASS and FAIL hold all outputs frozen until `start` or `reset`. Stores in IDLE, PASS or FAIL change nothing.
- `reset` has priority over `start` and `memwrite`.
- `cycle_count` cannot overflow, because its maximum value is TIMEOUT_CYCLES.

## Timing
- `start` sampled at edge N: `busy`=1 and all counters 0 from cycle N+1. The first monitored store is in cycle N+1.
- Store sampled at edge M in RUN:
  - Counters and captures are updated from cycle M+1.
  - On a match: `done`=`pass`=1 and `busy`=0 from cycle M+1, one cycle of latency.
- Frozen `cycle_count` equals the number of RUN cycles, including the terminating cycle.
- No store at all: FAIL from exactly TIMEOUT_CYCLES cycles after `busy` rose, with `cycle_count`=TIMEOUT_CYCLES.
- Reset asserted mid-RUN: all outputs 0 in the cycle after the reset edge.

## Test plan
- Arm with 18/21. Store (0x54,7), then (18,21) → PASS; `write_count`=2, `mismatch_count`=1, `last_adr`=0x54, `last_data`=7.
- Arm with TIMEOUT_CYCLES=200 and no stores → `busy` high for exactly 200 cycles, then `done`=1, `pass`=0, `cycle_count`=200.
- Arm with 84/7. Matching store on the 200th RUN cycle → PASS (not FAIL), `cycle_count`=200. The same store one cycle later → FAIL.
- Arm with 0x70f00ff0/2. Store (0x70f00ff0,3) → mismatch, `last_data`=3, still RUN. Then store (0x70f00ff0,2) → PASS.
- Matching store presented in the same cycle as `start` → ignored, `write_count`=0. Second `start` mid-RUN → counters cleared and new expected pair used.
- Assert `reset` mid-RUN with counters non-zero → all outputs 0 on the next cycle. Stores while IDLE → no counter changes.
